// File: rtl/qoi_chunk_scheduler_if.sv
// Pixel-in / byte-out bundle of the QOI chunk scheduler.
interface qoi_chunk_scheduler_if #(
  parameter int COMPONENTS = 4
);
  logic [8*COMPONENTS-1:0] pixel;
  logic                    pixel_valid;
  logic                    pixel_last;
  logic                    pixel_ready;
  logic [7:0]              ostream;
  logic                    wr_en;
  logic                    out_full;
  logic                    done;

  modport slave (
    input  pixel, pixel_valid, pixel_last, out_full,
    output pixel_ready, ostream, wr_en, done
  );

  modport master (
    output pixel, pixel_valid, pixel_last, out_full,
    input  pixel_ready, ostream, wr_en, done
  );
endinterface

// File: rtl/qoi_chunk_scheduler.sv
// QOI chunk encoder: classifies each pixel, serialises its 1-6 bytes, then the end marker.
// Latency: first byte of a pixel is offered the cycle after acceptance; at most 1 byte/cycle.
// Backpressure: out_full holds state, pointer and ostream; no pixel is accepted while emitting.
module qoi_chunk_scheduler #(
  parameter int COMPONENTS = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  qoi_chunk_scheduler_if.slave bus
);
  typedef enum logic [1:0] {ST_ACCEPT, ST_EMIT, ST_END, ST_DONE} state_t;
  localparam logic [31:0] PREV_RST = 32'h0000_00FF;

  state_t      state, state_n;
  logic [31:0] prev;
  logic [5:0]  run;
  logic [31:0] idx_tab [64];
  logic [7:0]  byte_buf [8];
  logic [2:0]  byte_cnt, ptr;
  logic        last_q, armed;

  logic [7:0]  cur_r, cur_g, cur_b, cur_a;
  logic [31:0] cur_px;
  logic        ready, wr, accept, px_eq, run_full, emit_last;
  logic [5:0]  run_inc;

  assign cur_r = bus.pixel[8*COMPONENTS-1 -: 8];
  assign cur_g = bus.pixel[8*COMPONENTS-9 -: 8];
  assign cur_b = bus.pixel[8*COMPONENTS-17 -: 8];
  if (COMPONENTS == 4) begin : g_alpha
    assign cur_a = bus.pixel[7:0];
  end else begin : g_opaque
    assign cur_a = 8'hFF;
  end
  assign cur_px = {cur_r, cur_g, cur_b, cur_a};

  assign accept    = ready & bus.pixel_valid;
  assign px_eq     = (cur_px == prev);
  assign run_inc   = run + 6'd1;
  assign run_full  = (run_inc == 6'd62);
  assign emit_last = (ptr == byte_cnt - 3'd1);

  // Hash kept wide before the mod so no product wraps early.
  logic [12:0] hash_sum;
  logic [5:0]  idx;
  assign hash_sum = {5'd0, cur_r} * 13'd3 + {5'd0, cur_g} * 13'd5
                  + {5'd0, cur_b} * 13'd7 + {5'd0, cur_a} * 13'd11;
  assign idx = 6'(hash_sum % 13'd64);

  logic [7:0]        dr, dg, db;
  logic signed [9:0] sdr, sdg, sdb, ldr, ldb;
  logic              a_eq, tab_hit, diff_ok, luma_ok;
  assign dr  = cur_r - prev[31:24];
  assign dg  = cur_g - prev[23:16];
  assign db  = cur_b - prev[15:8];
  assign sdr = {{2{dr[7]}}, dr};
  assign sdg = {{2{dg[7]}}, dg};
  assign sdb = {{2{db[7]}}, db};
  assign ldr = sdr - sdg;
  assign ldb = sdb - sdg;

  assign a_eq    = (cur_a == prev[7:0]);
  assign tab_hit = (idx_tab[idx] == cur_px);
  assign diff_ok = a_eq && sdr >= -10'sd2 && sdr <= 10'sd1 && sdg >= -10'sd2 && sdg <= 10'sd1
                        && sdb >= -10'sd2 && sdb <= 10'sd1;
  assign luma_ok = a_eq && sdg >= -10'sd32 && sdg <= 10'sd31 && ldr >= -10'sd8 && ldr <= 10'sd7
                        && ldb >= -10'sd8 && ldb <= 10'sd7;

  logic [7:0] op [5];
  logic [2:0] op_len, cnt_n;
  logic [7:0] buf_n [8];

  always_comb begin
    for (int i = 0; i < 5; i++) op[i] = 8'd0;
    op_len = 3'd1;
    if (tab_hit) begin
      op[0] = {2'b00, idx};
    end else if (diff_ok) begin
      op[0] = {2'b01, dr[1:0] + 2'd2, dg[1:0] + 2'd2, db[1:0] + 2'd2};
    end else if (luma_ok) begin
      op[0]  = {2'b10, dg[5:0] + 6'd32};
      op[1]  = {ldr[3:0] + 4'd8, ldb[3:0] + 4'd8};
      op_len = 3'd2;
    end else if (a_eq) begin
      op[0]  = 8'hFE;
      op[1]  = cur_r;
      op[2]  = cur_g;
      op[3]  = cur_b;
      op_len = 3'd4;
    end else begin
      op[0]  = 8'hFF;
      op[1]  = cur_r;
      op[2]  = cur_g;
      op[3]  = cur_b;
      op[4]  = cur_a;
      op_len = 3'd5;
    end

    // A pending run is flushed ahead of the op for the differing pixel.
    for (int i = 0; i < 8; i++) buf_n[i] = 8'd0;
    if (run != 6'd0) begin
      buf_n[0] = {2'b11, run - 6'd1};
      for (int i = 0; i < 5; i++) buf_n[i+1] = op[i];
      cnt_n = op_len + 3'd1;
    end else begin
      for (int i = 0; i < 5; i++) buf_n[i] = op[i];
      cnt_n = op_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ACCEPT;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    ready       = 1'b0;
    wr          = 1'b0;
    bus.ostream = 8'd0;
    bus.done    = 1'b0;
    case (state)
      ST_ACCEPT: begin
        ready = armed;
        if (accept && (!px_eq || run_full || bus.pixel_last)) state_n = ST_EMIT;
      end
      ST_EMIT: begin
        wr          = !bus.out_full;
        bus.ostream = byte_buf[ptr];
        if (wr && emit_last) state_n = last_q ? ST_END : ST_ACCEPT;
      end
      ST_END: begin
        wr          = !bus.out_full;
        bus.ostream = {7'd0, ptr == 3'd7};
        if (wr && ptr == 3'd7) state_n = ST_DONE;
      end
      ST_DONE: begin
        bus.done = 1'b1;
        state_n  = ST_ACCEPT;
      end
      default: state_n = ST_ACCEPT;
    endcase
  end

  assign bus.pixel_ready = ready;
  assign bus.wr_en       = wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= PREV_RST;
      run      <= 6'd0;
      byte_cnt <= 3'd0;
      ptr      <= 3'd0;
      last_q   <= 1'b0;
      armed    <= 1'b0;
      for (int i = 0; i < 64; i++) idx_tab[i] <= 32'd0;
      for (int i = 0; i < 8; i++) byte_buf[i] <= 8'd0;
    end else begin
      armed <= 1'b1;
      case (state)
        ST_ACCEPT: begin
          if (accept) begin
            last_q <= bus.pixel_last;
            ptr    <= 3'd0;
            if (px_eq) begin
              if (run_full || bus.pixel_last) begin
                byte_buf[0] <= {2'b11, run};
                byte_cnt    <= 3'd1;
                run         <= 6'd0;
              end else begin
                run <= run_inc;
              end
            end else begin
              for (int i = 0; i < 8; i++) byte_buf[i] <= buf_n[i];
              byte_cnt     <= cnt_n;
              run          <= 6'd0;
              idx_tab[idx] <= cur_px;
              prev         <= cur_px;
            end
          end
        end
        ST_EMIT: if (wr) ptr <= emit_last ? 3'd0 : ptr + 3'd1;
        ST_END:  if (wr) ptr <= ptr + 3'd1;
        ST_DONE: begin
          prev <= PREV_RST;
          run  <= 6'd0;
          for (int i = 0; i < 64; i++) idx_tab[i] <= 32'd0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_qoi_chunk_scheduler.sv
// Scoreboard bench: a QOI reference model queues expected bytes, a monitor checks every write and done pulse.
module tb_qoi_chunk_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qoi_chunk_scheduler_if #(.COMPONENTS(4)) bus ();
  qoi_chunk_scheduler #(.COMPONENTS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt   = 0;
  int exp_q[$];
  bit stall_en = 1'b0;

  logic [31:0] m_prev;
  int          m_run;
  logic [31:0] m_tab [64];

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp_v, exp_v, $time);
  endtask

  function automatic int sw(input int x);
    return ((x + 128) & 255) - 128;
  endfunction

  function automatic logic [31:0] rgba(input int r, input int g, input int b, input int a);
    return {8'(r), 8'(g), 8'(b), 8'(a)};
  endfunction

  task automatic model_reset();
    m_prev = 32'h0000_00FF;
    m_run  = 0;
    for (int i = 0; i < 64; i++) m_tab[i] = 32'd0;
  endtask

  // Reference QOI encoder step; value 256 in the queue stands for the done pulse.
  task automatic model_pixel(input logic [31:0] px, input bit last);
    int r, g, b, a, idx, dr, dg, db;
    r = int'(px[31:24]); g = int'(px[23:16]); b = int'(px[15:8]); a = int'(px[7:0]);
    if (px == m_prev) begin
      m_run++;
      if (m_run == 62 || last) begin
        exp_q.push_back(192 + m_run - 1);
        m_run = 0;
      end
    end else begin
      if (m_run > 0) exp_q.push_back(192 + m_run - 1);
      m_run = 0;
      idx = (r * 3 + g * 5 + b * 7 + a * 11) % 64;
      dr = sw(r - int'(m_prev[31:24]));
      dg = sw(g - int'(m_prev[23:16]));
      db = sw(b - int'(m_prev[15:8]));
      if (m_tab[idx] == px) begin
        exp_q.push_back(idx);
      end else if (a == int'(m_prev[7:0]) && dr >= -2 && dr <= 1 && dg >= -2 && dg <= 1 && db >= -2 && db <= 1) begin
        exp_q.push_back(64 + (dr + 2) * 16 + (dg + 2) * 4 + (db + 2));
      end else if (a == int'(m_prev[7:0]) && dg >= -32 && dg <= 31 && dr - dg >= -8 && dr - dg <= 7
                   && db - dg >= -8 && db - dg <= 7) begin
        exp_q.push_back(128 + dg + 32);
        exp_q.push_back((dr - dg + 8) * 16 + (db - dg + 8));
      end else if (a == int'(m_prev[7:0])) begin
        exp_q.push_back(254); exp_q.push_back(r); exp_q.push_back(g); exp_q.push_back(b);
      end else begin
        exp_q.push_back(255); exp_q.push_back(r); exp_q.push_back(g); exp_q.push_back(b); exp_q.push_back(a);
      end
      m_tab[idx] = px;
      m_prev = px;
    end
    if (last) begin
      repeat (7) exp_q.push_back(0);
      exp_q.push_back(1);
      exp_q.push_back(256);
      model_reset();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus.wr_en || bus.done)) begin
      int val;
      val = bus.done ? 256 : int'(bus.ostream);
      if (bus.wr_en && bus.done) chk("wr_en_with_done", 1, 0);
      chk("ready_low_while_busy", int'(bus.pixel_ready), 0);
      if (exp_q.size() == 0) chk("unexpected_output", val, -1);
      else chk("out_byte", val, exp_q.pop_front());
      if (bus.wr_en) wr_cnt++;
    end
  end

  initial begin
    bus.out_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_full = stall_en ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
  end

  task automatic send(input logic [31:0] px, input bit last);
    int t;
    bus.pixel = px;
    bus.pixel_last = last;
    bus.pixel_valid = 1'b1;
    for (t = 0; t < 500; t++) begin
      @(negedge clk);
      if (bus.pixel_ready) break;
    end
    if (t == 500) begin
      chk("accept_timeout", 0, 1);
      bus.pixel_valid = 1'b0;
      return;
    end
    model_pixel(px, last);
    @(posedge clk);
    #1;
    bus.pixel_valid = 1'b0;
    bus.pixel_last = 1'b0;
  endtask

  task automatic drain();
    int t;
    for (t = 0; t < 3000 && exp_q.size() != 0; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [31:0] gen(input logic [31:0] p);
    logic [31:0] q;
    int m;
    q = p;
    m = $urandom_range(0, 9);
    case (m)
      0, 1, 2: q = p;
      3, 4: begin
        q[31:24] = p[31:24] + 8'($urandom_range(0, 3)) - 8'd2;
        q[23:16] = p[23:16] + 8'($urandom_range(0, 3)) - 8'd2;
        q[15:8]  = p[15:8]  + 8'($urandom_range(0, 3)) - 8'd2;
      end
      5, 6: begin
        logic [7:0] d;
        d = 8'($urandom_range(0, 50)) - 8'd25;
        q[23:16] = p[23:16] + d;
        q[31:24] = p[31:24] + d + 8'($urandom_range(0, 15)) - 8'd8;
        q[15:8]  = p[15:8]  + d + 8'($urandom_range(0, 15)) - 8'd8;
      end
      7: q = rgba(40 * $urandom_range(0, 3), 17, 200, 255);
      8: q = {8'($urandom), 8'($urandom), 8'($urandom), 8'hFF};
      default: q = $urandom;
    endcase
    return q;
  endfunction

  initial begin
    logic [31:0] p;
    int base, t, len;
    bus.pixel = '0;
    bus.pixel_valid = 1'b0;
    bus.pixel_last = 1'b0;
    model_reset();

    #2;
    chk("rst_pixel_ready", int'(bus.pixel_ready), 0);
    chk("rst_wr_en", int'(bus.wr_en), 0);
    chk("rst_ostream", int'(bus.ostream), 0);
    chk("rst_done", int'(bus.done), 0);
    #20 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("ready_after_reset", int'(bus.pixel_ready), 1);

    send(rgba(0, 0, 0, 255), 1'b1);
    drain();

    send(rgba(1, 1, 1, 255), 1'b0);
    send(rgba(11, 11, 11, 255), 1'b1);
    drain();

    send(rgba(100, 0, 0, 255), 1'b0);
    send(rgba(0, 0, 200, 255), 1'b0);
    send(rgba(100, 0, 0, 255), 1'b1);
    drain();

    for (int i = 0; i < 63; i++) send(rgba(0, 0, 0, 255), i == 62);
    drain();
    send(rgba(0, 0, 0, 128), 1'b1);
    drain();

    stall_en = 1'b1;
    send(rgba(100, 0, 0, 255), 1'b0);
    send(rgba(0, 0, 200, 255), 1'b1);
    drain();
    stall_en = 1'b0;
    @(posedge clk);
    #1;

    // Reset lands right after FE 64 has been written.
    base = wr_cnt;
    send(rgba(100, 0, 0, 255), 1'b0);
    for (t = 0; t < 100; t++) begin
      @(posedge clk);
      if (wr_cnt == base + 2) break;
    end
    chk("bytes_before_reset", wr_cnt - base, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_drops_wr_en", int'(bus.wr_en), 0);
    chk("reset_drops_done", int'(bus.done), 0);
    chk("reset_drops_ready", int'(bus.pixel_ready), 0);
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send(rgba(100, 0, 0, 255), 1'b1);
    drain();

    for (int f = 0; f < 8; f++) begin
      stall_en = f[0];
      len = $urandom_range(1, 40);
      p = 32'h0000_00FF;
      for (int i = 0; i < len; i++) begin
        p = gen(p);
        send(p, i == len - 1);
      end
      drain();
    end
    stall_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
